// File: rtl/tnoc_packet_arbiter.sv
// Packet-granular round-robin arbiter for one router output port.
// Optional stall watchdog: define TNOC_PACKET_ARBITER_WATCHDOG_EN.
module tnoc_packet_arbiter #(
  parameter int REQUESTERS      = 5,
  parameter int WATCHDOG_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REQUESTERS-1:0] i_request,
  input  logic [REQUESTERS-1:0] i_tail,
  input  logic                  i_ready,
  output logic [REQUESTERS-1:0] o_grant,
  output logic                  o_valid,
  output logic [REQUESTERS-1:0] o_ready,
`ifdef TNOC_PACKET_ARBITER_WATCHDOG_EN
  output logic                  o_stall_error,
`endif
  output logic                  o_busy
);

  localparam int PW = $clog2(REQUESTERS);
  localparam logic [PW-1:0] LAST = PW'(REQUESTERS - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e                  state_q, state_d;
  logic [REQUESTERS-1:0]   grant_q, grant_d;
  logic [PW-1:0]           ptr_q, ptr_d;

  logic                    transfer;
  logic                    tail_done;
  logic [PW-1:0]           cur_idx;
  logic [PW-1:0]           nxt_ptr;
  logic [REQUESTERS-1:0]   scan_req;
  logic [PW-1:0]           scan_start;
  logic                    win_found;
  logic [PW-1:0]           win_idx;
  logic [REQUESTERS-1:0]   win_onehot;

  assign o_grant   = grant_q;
  assign o_valid   = |(grant_q & i_request);
  assign o_ready   = grant_q & {REQUESTERS{i_ready}};
  assign o_busy    = (state_q == BUSY);
  assign transfer  = o_valid & i_ready;
  assign tail_done = transfer & |(grant_q & i_tail);

  always_comb begin
    cur_idx = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (grant_q[i]) cur_idx = PW'(i);
    end
  end

  assign nxt_ptr = (cur_idx == LAST) ? '0 : cur_idx + PW'(1);

  // In BUSY the scan only matters on tail_done; the finisher is masked out.
  assign scan_req   = (state_q == BUSY) ? (i_request & ~grant_q) : i_request;
  assign scan_start = (state_q == BUSY) ? nxt_ptr : ptr_q;

  always_comb begin : scan
    int j;
    win_found = 1'b0;
    win_idx   = '0;
    j         = 0;
    for (int i = 0; i < REQUESTERS; i++) begin
      j = int'(scan_start) + i;
      if (j >= REQUESTERS) j = j - REQUESTERS;
      if (!win_found && scan_req[j]) begin
        win_found = 1'b1;
        win_idx   = PW'(j);
      end
    end
  end

  assign win_onehot =
    {{(REQUESTERS-1){1'b0}}, 1'b1} << win_idx;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d = win_onehot;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (tail_done) begin
          ptr_d = nxt_ptr;
          if (win_found) begin
            grant_d = win_onehot;
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef TNOC_PACKET_ARBITER_WATCHDOG_EN
  localparam int CW = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [CW-1:0] WD_MAX = CW'(WATCHDOG_CYCLES);

  logic [CW-1:0] wd_q, wd_d;
  logic          stall_q, stall_d;

  always_comb begin
    wd_d = wd_q;
    if (state_q != BUSY || transfer) begin
      wd_d = '0;
    end else if (wd_q != WD_MAX) begin
      wd_d = wd_q + CW'(1);
    end
    stall_d = stall_q | (wd_d == WD_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q    <= '0;
      stall_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      stall_q <= stall_d;
    end
  end

  assign o_stall_error = stall_q;
`endif

endmodule
